// File: rtl/mem_access_unit.sv
// Load/store initiator for a single-port word memory. Sub-word stores run as read-modify-write.
// Optional build macro MAU_MISALIGN_TRAP_EN: misaligned half/word accesses return an error.
module mem_access_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_out,
  input  logic [31:0] mem_data_in,
  output logic        mem_we,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken on a rising edge where req_valid & req_ready;
  // rsp_valid is a single-cycle pulse with no backpressure, and req_ready stays
  // low from acceptance until the cycle after that pulse.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  state_t      state, state_next;

  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        size_bad, range_bad, misalign_bad, req_err;
  logic [31:0] eff_addr;
  logic        accept;

  logic        rsp_valid_n, rsp_err_n, mem_we_n;
  logic [31:0] rsp_rdata_n, mem_address_n, mem_data_out_n;

  assign accept    = req_valid & req_ready;
  assign dbg_state = state;

  assign size_bad  = (req_size == 2'd3);
  assign range_bad = ({1'b0, req_addr} >= ADDR_LIMIT);

`ifdef MAU_MISALIGN_TRAP_EN
  assign misalign_bad = ((req_size == 2'd1) && req_addr[0]) ||
                        ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign eff_addr     = req_addr;
`else
  assign misalign_bad = 1'b0;
  always_comb begin
    eff_addr = req_addr;
    if (req_size == 2'd1) eff_addr[0]   = 1'b0;
    if (req_size == 2'd2) eff_addr[1:0] = 2'b00;
  end
`endif

  assign req_err = size_bad | range_bad | misalign_bad;

  // Select the addressed lane and sign/zero-extend it to a full word.
  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    r = {{24{b[7]  & ~uns}}, b};
      2'd1:    r = {{16{h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half of the read-back word with the store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic [15:0] data);
    logic [31:0] r;
    r = word;
    if (size == 2'd0) begin
      case (lane)
        2'd0:    r[7:0]   = data[7:0];
        2'd1:    r[15:8]  = data[7:0];
        2'd2:    r[23:16] = data[7:0];
        default: r[31:24] = data[7:0];
      endcase
    end else begin
      if (lane[1]) r[31:16] = data;
      else         r[15:0]  = data;
    end
    return r;
  endfunction

  always_comb begin
    state_next     = state;
    rsp_valid_n    = 1'b0;
    rsp_err_n      = 1'b0;
    rsp_rdata_n    = 32'd0;
    mem_we_n       = 1'b0;
    mem_address_n  = mem_address;
    mem_data_out_n = mem_data_out;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_next  = RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
          end else begin
            mem_address_n = {eff_addr[31:2], 2'b00};
            if (req_we && (req_size == 2'd2)) begin
              state_next     = WRITE;
              mem_we_n       = 1'b1;
              mem_data_out_n = req_wdata;
            end else begin
              state_next = READ;
            end
          end
        end
      end
      READ: begin
        if (we_q) begin
          state_next     = WRITE;
          mem_we_n       = 1'b1;
          mem_data_out_n = merge_store(mem_data_in, size_q, lane_q, wdata_q);
        end else begin
          state_next  = RESP;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = extend_load(mem_data_in, size_q, lane_q, uns_q);
        end
      end
      WRITE: begin
        state_next  = RESP;
        rsp_valid_n = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= 32'd0;
      mem_we       <= 1'b0;
      mem_address  <= 32'd0;
      mem_data_out <= 32'd0;
    end else begin
      state        <= state_next;
      req_ready    <= (state_next == IDLE);
      rsp_valid    <= rsp_valid_n;
      rsp_err      <= rsp_err_n;
      rsp_rdata    <= rsp_rdata_n;
      mem_we       <= mem_we_n;
      mem_address  <= mem_address_n;
      mem_data_out <= mem_data_out_n;
    end
  end

  // Request fields held for the READ/WRITE phases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      lane_q  <= 2'd0;
      wdata_q <= 16'd0;
    end else if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      lane_q  <= eff_addr[1:0];
      wdata_q <= req_wdata[15:0];
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: behavioural memory, reference model and response scoreboard.
module tb_mem_access_unit;

  localparam int MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_address, mem_data_out, mem_data_in;
  logic        mem_we;
  logic [1:0]  dbg_state;

  logic [31:0] mem     [0:MEM_WORDS-1];
  logic [31:0] exp_mem [0:MEM_WORDS-1];
  logic [32:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_we(mem_we), .dbg_state(dbg_state)
  );

  // clock / memory
  always #5 clk = ~clk;

  assign mem_data_in = mem[mem_address[11:2]];

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_address[11:2]] <= mem_data_out;
      we_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: pop one expectation per response pulse
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
        check("rsp_rdata", rsp_rdata, e[31:0]);
      end
    end
  end

  // reference model: little-endian lanes, extension, RMW, error priority
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rdata,
                       output int lat, output int wes, output int idx);
    logic [31:0] a, old, mask, lane;
    int sh;
    err = 1'b0; rdata = 32'd0; wes = 0; idx = 0; lat = 1;
    a = addr;
    if (size == 2'd3) err = 1'b1;
    else if (addr >= 32'(MEM_WORDS * 4)) err = 1'b1;
`ifdef MAU_MISALIGN_TRAP_EN
    else if ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)) err = 1'b1;
`else
    if (size == 2'd1) a[0] = 1'b0;
    if (size == 2'd2) a[1:0] = 2'b00;
`endif
    if (!err) begin
      idx  = int'(a[11:2]);
      old  = exp_mem[idx];
      sh   = 8 * int'(a[1:0]);
      mask = (size == 2'd0) ? 32'h0000_00FF : (size == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      if (!we) begin
        lane = (old >> sh) & mask;
        if (!uns && size == 2'd0 && lane[7])  lane = lane | 32'hFFFF_FF00;
        if (!uns && size == 2'd1 && lane[15]) lane = lane | 32'hFFFF_0000;
        rdata = lane;
        lat   = 2;
      end else begin
        exp_mem[idx] = (old & ~(mask << sh)) | ((wdata & mask) << sh);
        wes = 1;
        lat = (size == 2'd2) ? 2 : 3;
      end
    end
  endtask

  // driver: one request, latency/write-pulse/memory checks
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic        e_err;
    logic [31:0] e_rdata;
    int e_lat, e_wes, idx, lat, n;
    bit done;
    model(we, size, uns, addr, wdata, e_err, e_rdata, e_lat, e_wes, idx);
    exp_q.push_back({e_err, e_rdata});
    @(negedge clk);
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) check("ready_timeout", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    we_cnt = 0;
    @(posedge clk);
    lat = 0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      lat++;
      @(negedge clk);
      req_valid = 1'b0;
      req_wdata = $urandom;
      if (rsp_valid === 1'b1) done = 1'b1;
      else @(posedge clk);
    end
    if (!done) check("rsp_timeout", 32'd0, 32'd1);
    check("latency", 32'(lat), 32'(e_lat));
    check("we_pulses", 32'(we_cnt), 32'(e_wes));
    if (e_wes != 0) check("mem_word", mem[idx], exp_mem[idx]);
  endtask

  // reset asserted while the store sits in WRITE; memory must not change
  task automatic reset_mid_write(input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata);
    logic [31:0] old;
    int n;
    old = mem[addr[11:2]];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = size; req_unsigned = 1'b0;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (mem_we !== 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("reached_write", {31'd0, mem_we}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("we_async_drop", {31'd0, mem_we}, 32'd0);
    check("ready_in_reset", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_mem", mem[addr[11:2]], old);
    check("ready_after", {31'd0, req_ready}, 32'd1);
    check("idle_after", {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      v = $urandom;
      mem[i] = v;
      exp_mem[i] = v;
    end
    mem[3] = 32'h8899_AABB;
    exp_mem[3] = 32'h8899_AABB;

    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_data_out", mem_data_out, 32'd0);
    reset = 1'b0;

    // directed cases against known constants
    exp_q.push_back({1'b0, 32'hFFFF_FF99});
    do_req(1'b0, 2'd0, 1'b0, 32'h0E, 32'd0);
    void'(exp_q.pop_back());
    do_req(1'b0, 2'd0, 1'b1, 32'h0E, 32'd0);
    check("const_half", {16'hFFFF, exp_mem[3][15:0]}, 32'hFFFF_AABB);
    do_req(1'b0, 2'd1, 1'b0, 32'h0C, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0C, 32'd0);
    do_req(1'b1, 2'd0, 1'b0, 32'h0D, 32'h1234_56CC);
    check("mem3_byte_store", mem[3], 32'h8899_CCBB);
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("mem4_word_store", mem[4], 32'hDEAD_BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0E, 32'd0);
    do_req(1'b0, 2'd3, 1'b0, 32'h08, 32'd0);
    do_req(1'b1, 2'd1, 1'b0, 32'h0FFF, 32'h0000_5A5A);
    do_req(1'b1, 2'd1, 1'b0, 32'h0FFE, 32'hFFFF_8001);
    do_req(1'b0, 2'd1, 1'b0, 32'h0FFE, 32'd0);

    // reset during WRITE: word store and RMW byte store
    reset_mid_write(2'd2, 32'h20, 32'hCAFE_F00D);
    reset_mid_write(2'd0, 32'h25, 32'h0000_0077);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  sz;
      logic [31:0] ad;
      int s;
      s  = $urandom_range(0, 9);
      sz = (s == 9) ? 2'd3 : 2'(s % 3);
      ad = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'($urandom_range(0, 255))
                                       : 32'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
